pe_mac_sequencer: RTL

Control stage that sits directly upstream of the PE compute unit (computer_unit) and drives its op ports. It takes operand pairs (data, weight) over a valid/ready stream and issues a MUL then an ADD to the CU for each pair. It reads the CU result back to keep a 32-bit dot-product accumulator, and presents the final sum on a valid/ready result port. The PE top instantiates both blocks side by side.

---
 rtl/pe_pkg.sv | 22 ++
 rtl/pe_mac_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the PE: compute-unit opcodes, datapath width and
// the MAC sequencer state encoding.
package pe_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SEL_SUB = 2'b00;
  localparam logic [1:0] SEL_CMP = 2'b01;
  localparam logic [1:0] SEL_ADD = 2'b10;
  localparam logic [1:0] SEL_MUL = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StMul,
    StAddSet,
    StAdd,
    StWb,
    StOut
  } seq_state_e;

endpackage

// File: rtl/pe_mac_sequencer.sv
// Drives the PE compute unit with a MUL then an ADD per operand pair and keeps
// a running dot-product sum, returned over a valid/ready result port.
module pe_mac_sequencer
  import pe_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_par,
  output logic              cu_enable,
  output logic [DATA_W-1:0] cu_data,
  output logic [DATA_W-1:0] cu_par,
  output logic [1:0]        cu_sel,
  input  logic [DATA_W-1:0] cu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy
);

  seq_state_e        r_state, w_state_next;
  logic [DATA_W-1:0] r_acc;
  logic [LEN_W-1:0]  r_count, r_len;
  logic [DATA_W-1:0] r_res_data;
  logic              r_cu_enable;
  logic [DATA_W-1:0] r_cu_data, r_cu_par;
  logic [1:0]        r_cu_sel;
  logic [LEN_W-1:0]  w_count_inc;
  logic              w_last;

  assign w_count_inc = r_count + LEN_W'(1);
  assign w_last      = (w_count_inc == r_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (start) w_state_next = (vec_len == '0) ? StOut : StFetch;
      StFetch:  if (in_valid) w_state_next = StMul;
      StMul:    w_state_next = StAddSet;
      StAddSet: w_state_next = StAdd;
      StAdd:    w_state_next = StWb;
      StWb:     w_state_next = w_last ? StOut : StFetch;
      StOut:    if (res_ready) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_len       <= '0;
      r_res_data  <= '0;
      r_cu_enable <= 1'b0;
      r_cu_data   <= '0;
      r_cu_par    <= '0;
      r_cu_sel    <= SEL_SUB;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_len   <= vec_len;
            r_acc   <= '0;
            r_count <= '0;
            if (vec_len == '0) r_res_data <= '0;
          end
        end
        StFetch: begin
          if (in_valid) begin
            r_cu_data   <= in_data;
            r_cu_par    <= in_par;
            r_cu_sel    <= SEL_MUL;
            r_cu_enable <= 1'b1;
          end
        end
        StMul: r_cu_enable <= 1'b0;
        // Product is on cu_out now; feed it back with the running sum.
        StAddSet: begin
          r_cu_data   <= cu_out;
          r_cu_par    <= r_acc;
          r_cu_sel    <= SEL_ADD;
          r_cu_enable <= 1'b1;
        end
        StAdd: r_cu_enable <= 1'b0;
        StWb: begin
          r_acc   <= cu_out;
          r_count <= w_count_inc;
          if (w_last) r_res_data <= cu_out;
        end
        StOut: if (res_ready) r_acc <= '0;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == StFetch);
  assign res_valid = (r_state == StOut);
  assign busy      = (r_state != StIdle);
  assign res_data  = r_res_data;
  assign cu_enable = r_cu_enable;
  assign cu_data   = r_cu_data;
  assign cu_par    = r_cu_par;
  assign cu_sel    = r_cu_sel;

endmodule
